// File: rtl/ifetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Circular FIFO holding fetched {pc, instr} entries; combinational head read.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_push   = push && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // The issue gating upstream guarantees a free slot for every response.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      assert (!full);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: PC register driving a 1-cycle imem, responses buffered for decode.
// Redirect flushes the queue, drops the in-flight read and restarts at the new PC.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        decode_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc_q;
  logic         inflight_q;
  logic [CW-1:0] count;
  logic [CW:0]  occupancy;
  logic         empty;
  logic         issue;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // Conservative: a same-cycle pop does not free a slot for issue.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};
  assign inst_valid = !empty;
  assign inst       = head_entry.instr;
  assign inst_pc    = head_entry.pc;
  assign pop        = inst_valid && decode_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      inflight_pc_q <= {RESET_PC[31:2], 2'b00};
      inflight_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a 1-cycle synchronous memory model.
module tb_ifetch_queue;

  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        decode_ready;

  int checks = 0;
  int passed = 0;

  ifetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .decode_ready   (decode_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem_addr ^ SIG;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with reset low ("cycle 1").
  task automatic do_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    decode_ready = 1'b1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    checks++; if (imem_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", imem_rd_en); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", inst_valid); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_stream;
    do_reset();
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) $display("FAIL stream_c1 got en=%b addr=%h want 1/0", imem_rd_en, imem_addr); else passed++;
    step();
    checks++; if (imem_addr !== 32'h4 || inst_valid !== 1'b0) $display("FAIL stream_c2 got addr=%h v=%b want 4/0", imem_addr, inst_valid); else passed++;
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k) || inst !== (32'(4*k) ^ SIG) || imem_addr !== 32'(4*k+8))
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h addr=%h want 1/%h/%h/%h",
                 k, inst_valid, inst_pc, inst, imem_addr, 32'(4*k), 32'(4*k) ^ SIG, 32'(4*k+8));
      else passed++;
      step();
    end
  endtask

  task automatic test_backpressure;
    int issues;
    decode_ready = 1'b0;
    do_reset();
    issues = 0;
    for (int c = 0; c < 20; c++) begin
      if (imem_rd_en) issues++;
      step();
    end
    checks++; if (issues !== 8) $display("FAIL bp_issues got %0d want 8", issues); else passed++;
    checks++; if (imem_rd_en !== 1'b0) $display("FAIL bp_rd_en got %b want 0", imem_rd_en); else passed++;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL bp_head got v=%b pc=%h want 1/0", inst_valid, inst_pc); else passed++;
    decode_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k) || inst !== (32'(4*k) ^ SIG))
        $display("FAIL bp_drain_%0d got v=%b pc=%h inst=%h want 1/%h", k, inst_valid, inst_pc, inst, 32'(4*k));
      else passed++;
      step();
    end
  endtask

  task automatic test_redirect;
    decode_ready = 1'b1;
    do_reset();
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    checks++; if (imem_rd_en !== 1'b0) $display("FAIL redir_t_rd_en got %b want 0", imem_rd_en); else passed++;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0)
      $display("FAIL redir_t1 got en=%b addr=%h v=%b want 1/100/0", imem_rd_en, imem_addr, inst_valid); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL redir_t2 got v=%b want 0", inst_valid); else passed++;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(32'h100 + 4*k))
        $display("FAIL redir_seq_%0d got v=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 32'(32'h100 + 4*k));
      else passed++;
      step();
    end
  endtask

  task automatic test_redirect_full;
    decode_ready = 1'b0;
    do_reset();
    repeat (12) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h200)
      $display("FAIL full_redir_t1 got v=%b addr=%h want 0/200", inst_valid, imem_addr); else passed++;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== (32'h200 ^ SIG))
      $display("FAIL full_redir_head got v=%b pc=%h inst=%h want 1/200/%h", inst_valid, inst_pc, inst, 32'h200 ^ SIG); else passed++;
    repeat (4) step();
    checks++; if (inst_pc !== 32'h200) $display("FAIL full_redir_hold got pc=%h want 200", inst_pc); else passed++;
  endtask

  task automatic test_back_to_back;
    decode_ready = 1'b1;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    #1;
    checks++; if (imem_rd_en !== 1'b0) $display("FAIL b2b_t1_rd_en got %b want 0", imem_rd_en); else passed++;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h80 || imem_rd_en !== 1'b1) $display("FAIL b2b_t2 got en=%b addr=%h want 1/80", imem_rd_en, imem_addr); else passed++;
    step();
    checks++; if (inst_valid !== 1'b0) $display("FAIL b2b_t3 got v=%b want 0", inst_valid); else passed++;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(32'h80 + 4*k))
        $display("FAIL b2b_seq_%0d got v=%b pc=%h want 1/%h", k, inst_valid, inst_pc, 32'(32'h80 + 4*k));
      else passed++;
      step();
    end
  endtask

  task automatic test_pc_wrap;
    decode_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_a got v=%b pc=%h want 1/fffffffc", inst_valid, inst_pc); else passed++;
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL wrap_b got v=%b pc=%h want 1/0", inst_valid, inst_pc); else passed++;
  endtask

  task automatic test_reset_with_redirect;
    decode_ready = 1'b1;
    do_reset();
    repeat (6) step();
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    checks++; if (inst_valid !== 1'b0 || imem_rd_en !== 1'b0)
      $display("FAIL rst_redir got v=%b en=%b want 0/0", inst_valid, imem_rd_en); else passed++;
    reset = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0 || imem_rd_en !== 1'b1)
      $display("FAIL rst_redir_resume got en=%b addr=%h want 1/0", imem_rd_en, imem_addr); else passed++;
    step();
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
      $display("FAIL rst_redir_head got v=%b pc=%h want 1/0", inst_valid, inst_pc); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    decode_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_back_to_back();
    test_pc_wrap();
    test_reset_with_redirect();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
